// File: rtl/cnt60.sv
// cnt60: modulo-60 counter held as two BCD digits plus a parallel binary
// register. The carry output feeds the next cascaded stage; only the time-base
// enable ripples out, so a manual adjust never disturbs the next stage.
module cnt60 (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_en,
  input  logic       cnt_inc,
  output logic [2:0] cnt_hi,
  output logic [3:0] cnt_lo,
  output logic [5:0] cnt_bin,
  output logic       co
);

  logic [2:0] r_hi;
  logic [3:0] r_lo;
  logic [5:0] r_bin;

  logic       w_adv;
  logic       w_lo_max;
  logic       w_at59;

  assign w_adv    = cnt_en | cnt_inc;
  assign w_lo_max = (r_lo == 4'd9);
  assign w_at59   = w_lo_max && (r_hi == 3'd5);

  // Advance BCD digits and binary view together so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi  <= 3'd0;
      r_lo  <= 4'd0;
      r_bin <= 6'd0;
    end else if (w_adv) begin
      if (w_at59) begin
        r_hi  <= 3'd0;
        r_lo  <= 4'd0;
        r_bin <= 6'd0;
      end else begin
        if (w_lo_max) begin
          r_lo <= 4'd0;
          r_hi <= r_hi + 3'd1;
        end else begin
          r_lo <= r_lo + 4'd1;
        end
        r_bin <= r_bin + 6'd1;
      end
    end
  end

  assign cnt_hi  = r_hi;
  assign cnt_lo  = r_lo;
  assign cnt_bin = r_bin;
  // Carry is held low during reset so the next stage never sees a spurious tick.
  assign co      = cnt_en & ~rst & w_at59;

endmodule

// File: tb/tb_cnt60.sv
// tb_cnt60: scoreboard bench for cnt60. Each driven cycle pushes the expected
// post-edge count into a queue; the entry is popped and compared after the edge.
module tb_cnt60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt_en = 1'b0;
  logic       cnt_inc = 1'b0;
  logic [2:0] cnt_hi;
  logic [3:0] cnt_lo;
  logic [5:0] cnt_bin;
  logic       co;

  int n_chk = 0;
  int n_bad = 0;
  int m_cnt = 0;
  int co_seen = 0;
  int exp_q[$];

  cnt60 dut (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (cnt_en),
    .cnt_inc (cnt_inc),
    .cnt_hi  (cnt_hi),
    .cnt_lo  (cnt_lo),
    .cnt_bin (cnt_bin),
    .co      (co)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check combinational carry, predict, then compare.
  task automatic step(input logic r, input logic en, input logic inc);
    int nxt;
    int e;
    rst = r; cnt_en = en; cnt_inc = inc;
    #1;
    check_eq("co", {31'd0, co}, {31'd0, (en && !r && m_cnt == 59)});
    if (co === 1'b1) co_seen++;
    if (r) nxt = 0;
    else if (en || inc) nxt = (m_cnt == 59) ? 0 : m_cnt + 1;
    else nxt = m_cnt;
    exp_q.push_back(nxt);
    m_cnt = nxt;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("hi", {29'd0, cnt_hi}, e / 10);
      check_eq("lo", {28'd0, cnt_lo}, e % 10);
      check_eq("bin", {26'd0, cnt_bin}, e);
      check_eq("bin_vs_bcd", {26'd0, cnt_bin}, 10 * cnt_hi + cnt_lo);
      check_eq("legal", {31'd0, (cnt_lo <= 4'd9 && cnt_hi <= 3'd5 && cnt_bin <= 6'd59)}, 32'd1);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset with enables high to show reset priority.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);

    // Time-base run: exactly one carry in 100 ticks, ending at 40.
    co_seen = 0;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
    check_eq("co_once", co_seen, 1);
    check_eq("run_end", {26'd0, cnt_bin}, 40);

    // Idle: frozen at 40.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    check_eq("frozen", {26'd0, cnt_bin}, 40);

    // Mid-count reset with enables asserted.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    check_eq("mid_rst", {26'd0, cnt_bin}, 0);

    // Manual increment run: wraps but never carries.
    co_seen = 0;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1);
    check_eq("inc_no_co", co_seen, 0);

    // Both enables together from 09 advance by one only.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check_eq("both_09", {26'd0, cnt_bin}, 10);
    check_eq("both_hi", {29'd0, cnt_hi}, 1);
    check_eq("both_lo", {28'd0, cnt_lo}, 0);

    // Random mix including occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 1));

    check_eq("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cnt60.md
CNT60 -- requirements
Module: cnt60

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single system clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and is the reset; it is synchronous and active-high.
REQ-004 The port cnt_en SHALL be an input, 1 bit wide, and is the count enable (the normal time-base tick); the counter advances by one on each clock where it is high.
REQ-005 The port cnt_inc SHALL be an input, 1 bit wide, and is the manual increment (the set/adjust input); the counter advances by one on each clock where it is high.
REQ-006 The port cnt_hi SHALL be an output, 3 bits wide, and is the BCD tens digit, 0..5.
REQ-007 The port cnt_lo SHALL be an output, 4 bits wide, and is the BCD units digit, 0..9.
REQ-008 The port cnt_bin SHALL be an output, 6 bits wide, and is the binary count value, 0..59, always equal to cnt_hi*10 + cnt_lo.
REQ-009 The port co SHALL be an output, 1 bit wide, and is the carry out to the next cascaded stage.

Function
REQ-010 The block SHALL implement a modulo-60 counter with state held as two BCD digits (hi 0..5, lo 0..9) plus a 6-bit binary register, all registered.
REQ-011 The advance condition SHALL be adv = cnt_en OR cnt_inc; if both are high in the same cycle, the counter advances by exactly one.
REQ-012 When adv=1 and lo<9, lo SHALL increment by 1 and hi SHALL be unchanged.
REQ-013 When adv=1 and lo=9 and hi<5, lo SHALL become 0 and hi SHALL increment by 1.
REQ-014 When adv=1 at count 59 (hi=5, lo=9), the counter SHALL wrap to 00 (hi=0, lo=0, bin=0).
REQ-015 When adv=0, all state SHALL hold its value.
REQ-016 cnt_bin SHALL update in the same clock edge as the BCD digits: +1 on advance, 59 -> 0 on wrap, with no lag between the binary and BCD views.
REQ-017 co SHALL be combinational: co = cnt_en AND (count == 59).
REQ-018 co SHALL therefore be high during the cycle whose rising edge produces the 59 -> 0 wrap.
REQ-019 cnt_inc alone SHALL NOT assert co, so that a manual adjust does not ripple into the next stage.
REQ-020 Outputs SHALL never show illegal values (lo>9, hi>5, bin>59) in any cycle after reset.
REQ-021 The latency from an enable being sampled to the output change SHALL be 1 clock.

Reset
REQ-022 While rst=1 at a rising clk edge, the block SHALL load cnt_hi=0, cnt_lo=0 and cnt_bin=0, and co SHALL be 0.
REQ-023 rst SHALL have priority over cnt_en and cnt_inc.
REQ-024 Reset asserted mid-count SHALL clear the count on the next edge, regardless of the current value.
REQ-025 Counting SHALL resume from 00 on the first edge with rst=0 and adv=1.
REQ-026 Before the first reset the register contents are undefined; no initial value is required.

Verification
REQ-027 Reset for 3 clocks, then hold cnt_en=1 for 100 clocks -> count goes 00,01..59,00..39 (bin matches); co is high exactly during cycles with count=59 (once in the run).
REQ-028 After that run, hold cnt_en=0 for 10 clocks -> outputs stay frozen at 40 and co=0.
REQ-029 Assert rst mid-count (e.g. at 40) for 3 clocks -> hi=0, lo=0, bin=0 on the first reset edge and held there; cnt_en/cnt_inc high during reset is ignored.
REQ-030 After reset, hold cnt_inc=1 and cnt_en=0 for 100 clocks -> same sequence as REQ-027, including the wrap 59->00, with co constantly 0.
REQ-031 Pulse cnt_en and cnt_inc together for one clock from 09 -> count becomes 10 (hi=1, lo=0, bin=10), not 11.
REQ-032 Check every cycle -> cnt_bin == 10*cnt_hi + cnt_lo, lo<=9, hi<=5.
